// File: rtl/seq1001_tx.sv
// Serial frame transmitter: sends preamble 1-0-0-1, then the payload MSB-first,
// then GAP idle zeros, one bit per clock on dout.
module seq1001_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAP    = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              tx_active,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);

    // One bit counter is shared by the preamble, payload and gap phases.
    localparam int unsigned MaxCnt = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                                    : ((GAP > 4) ? GAP : 4);
    localparam int unsigned CW = $clog2(MaxCnt + 1);

    localparam logic [CW-1:0] PreLast  = CW'(4);
    localparam logic [CW-1:0] DataLast = CW'(DATA_W);
    localparam logic [CW-1:0] GapLast  = CW'(GAP);
    localparam logic [CW-1:0] CntOne   = CW'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPre  = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StGap  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              dout_q, dout_d;
    logic              tx_active_q, tx_active_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    assign in_ready  = (state_q == StIdle);
    assign dout      = dout_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

    // Outputs are registered, so each branch computes the bit for the next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dout_d      = 1'b0;
        tx_active_d = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d     = StPre;
                    cnt_d       = CntOne;
                    shreg_d     = in_data;
                    dout_d      = 1'b1;
                    tx_active_d = 1'b1;
                end
            end
            StPre: begin
                tx_active_d = 1'b1;
                if (cnt_q == PreLast) begin
                    state_d = StData;
                    cnt_d   = CntOne;
                    dout_d  = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    dout_d = (cnt_q == CW'(3));
                    cnt_d  = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == DataLast) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (GAP > 0) begin
                        state_d = StGap;
                        cnt_d   = CntOne;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    tx_active_d = 1'b1;
                    dout_d      = shreg_q[DATA_W-1];
                    shreg_d     = shreg_q << 1;
                    cnt_d       = cnt_q + CntOne;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            dout_q      <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
